tcp_rx_record_writer: RTL and testbench

- Receive-side counterpart of the TX packet builder.
- Accepts an inbound Ethernet/IPv4/TCP frame as a 32-bit word stream and parses the header fields.
- Writes a 9-word connection record into the connection RAM, in the same layout the TX builder reads back.
- The valid word is written last, so a polling reader never sees a partially written record.

---
 rtl/tcp_rx_record_writer.sv | 256 +++++++++++++++++++++++++
 tb/tb_tcp_rx_record_writer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_rx_record_writer.sv
// Parses an inbound Ethernet/IPv4/TCP header from a 32-bit word stream and commits
// a 9-word connection record to RAM, writing the valid word last.
module tcp_rx_record_writer #(
  parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800,
  parameter logic [7:0]  PROTO_TCP      = 8'h06,
  parameter int          HDR_WORDS      = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  input  logic [8:0]  slot_base,
  output logic [8:0]  address,
  output logic [31:0] ram_out,
  output logic        wren,
  output logic        pkt_done,
  output logic        pkt_drop,
  output logic [15:0] drop_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    DROP    = 3'd3,
    WRITE   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_HDR = 4'(HDR_WORDS - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  widx_q, widx_d;
  logic [8:0]  base_q, base_d;
  logic [47:0] mac_dst_q, mac_dst_d, mac_src_q, mac_src_d;
  logic [31:0] ip_src_q, ip_src_d, ip_dst_q, ip_dst_d;
  logic [31:0] seq_q, seq_d, ack_q, ack_d;
  logic [15:0] sport_q, sport_d, dport_q, dport_d;
  logic [7:0]  flags_q, flags_d;
  logic [8:0]  address_q, address_d;
  logic [31:0] ram_out_q, ram_out_d;
  logic        wren_q, wren_d, done_q, done_d, drop_q, drop_d;
  logic [15:0] dcnt_q, dcnt_d;

  logic        xfer_s, start_s, hdr_word_s, cap_en_s, hdr_bad_s;
  logic        chk3_bad_s, chk5_bad_s, emit_en_s;
  logic [3:0]  cap_idx_s, emit_idx_s, rec_k_s;

  assign in_ready   = (state_q != WRITE);
  assign xfer_s     = in_valid && in_ready;
  // A sop transfer in any non-WRITE state (re)starts a frame at word 0.
  assign start_s    = xfer_s && in_sop;
  assign hdr_word_s = xfer_s && !in_sop && (state_q == HDR);
  assign cap_en_s   = start_s || hdr_word_s;
  assign cap_idx_s  = start_s ? 4'd0 : cnt_q;
  assign chk3_bad_s = (in_data[31:16] != ETHERTYPE_IPV4) || (in_data[15:12] != 4'd4) ||
                      (in_data[11:8] != 4'd5);
  assign chk5_bad_s = (in_data[7:0] != PROTO_TCP);
  assign hdr_bad_s  = hdr_word_s && (((cnt_q == 4'd3) && chk3_bad_s) ||
                                     ((cnt_q == 4'd5) && chk5_bad_s));

  // Header field capture, one slice per header word.
  always_comb begin
    mac_dst_d = mac_dst_q;
    mac_src_d = mac_src_q;
    ip_src_d  = ip_src_q;
    ip_dst_d  = ip_dst_q;
    sport_d   = sport_q;
    dport_d   = dport_q;
    seq_d     = seq_q;
    ack_d     = ack_q;
    flags_d   = flags_q;
    if (cap_en_s) begin
      case (cap_idx_s)
        4'd0: mac_dst_d[47:16] = in_data;
        4'd1: begin mac_dst_d[15:0] = in_data[31:16]; mac_src_d[47:32] = in_data[15:0]; end
        4'd2: mac_src_d[31:0] = in_data;
        4'd6: ip_src_d[31:16] = in_data[15:0];
        4'd7: begin ip_src_d[15:0] = in_data[31:16]; ip_dst_d[31:16] = in_data[15:0]; end
        4'd8: begin ip_dst_d[15:0] = in_data[31:16]; sport_d = in_data[15:0]; end
        4'd9: begin dport_d = in_data[31:16]; seq_d[31:16] = in_data[15:0]; end
        4'd10: begin seq_d[15:0] = in_data[31:16]; ack_d[31:16] = in_data[15:0]; end
        4'd11: begin ack_d[15:0] = in_data[31:16]; flags_d = in_data[7:0]; end
        default: mac_dst_d = mac_dst_q;
      endcase
    end else begin
      flags_d = flags_q;
    end
  end

  // Frame state machine; emit_* selects which record word goes out next cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    widx_d     = widx_q;
    drop_d     = 1'b0;
    emit_en_s  = 1'b0;
    emit_idx_s = 4'd0;
    case (state_q)
      IDLE, HDR, PAYLOAD, DROP: begin
        if (start_s) begin
          base_d = slot_base;
          drop_d = (state_q != IDLE) || in_eop;
          if (in_eop) begin
            state_d = IDLE;
          end else begin
            state_d = HDR;
            cnt_d   = 4'd1;
          end
        end else if (xfer_s) begin
          case (state_q)
            HDR: begin
              if (hdr_bad_s) begin
                if (in_eop) begin
                  drop_d  = 1'b1;
                  state_d = IDLE;
                end else begin
                  state_d = DROP;
                end
              end else if (cnt_q == LAST_HDR) begin
                if (in_eop) begin
                  state_d   = WRITE;
                  widx_d    = 4'd0;
                  emit_en_s = 1'b1;
                end else begin
                  state_d = PAYLOAD;
                end
              end else if (in_eop) begin
                drop_d  = 1'b1;
                state_d = IDLE;
              end else begin
                cnt_d = cnt_q + 4'd1;
              end
            end
            PAYLOAD: begin
              if (in_eop) begin
                state_d   = WRITE;
                widx_d    = 4'd0;
                emit_en_s = 1'b1;
              end else begin
                state_d = PAYLOAD;
              end
            end
            DROP: begin
              if (in_eop) begin
                drop_d  = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = DROP;
              end
            end
            default: state_d = state_q;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      WRITE: begin
        if (widx_q == 4'd8) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          widx_d     = widx_q + 4'd1;
          emit_en_s  = 1'b1;
          emit_idx_s = widx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Record word mux: slot offsets 1..8 first, valid word at offset 0 last.
  always_comb begin
    wren_d    = 1'b0;
    done_d    = 1'b0;
    address_d = address_q;
    ram_out_d = ram_out_q;
    rec_k_s   = (emit_idx_s == 4'd8) ? 4'd0 : emit_idx_s + 4'd1;
    if (emit_en_s) begin
      wren_d    = 1'b1;
      done_d    = (rec_k_s == 4'd0);
      address_d = base_q + {5'd0, rec_k_s};
      case (rec_k_s)
        4'd1: ram_out_d = seq_d;
        4'd2: ram_out_d = ack_d;
        4'd3: ram_out_d = ip_src_d;
        4'd4: ram_out_d = ip_dst_d;
        4'd5: ram_out_d = mac_src_d[31:0];
        4'd6: ram_out_d = {mac_dst_d[15:0], mac_src_d[47:32]};
        4'd7: ram_out_d = mac_dst_d[47:16];
        4'd8: ram_out_d = {dport_d, sport_d};
        default: ram_out_d = {flags_d, 23'd0, 1'b1};
      endcase
    end else begin
      ram_out_d = ram_out_q;
    end
    dcnt_d = (drop_d && (dcnt_q != 16'hFFFF)) ? dcnt_q + 16'd1 : dcnt_q;
  end

  // State, captured fields and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      widx_q    <= 4'd0;
      base_q    <= 9'd0;
      mac_dst_q <= 48'd0;
      mac_src_q <= 48'd0;
      ip_src_q  <= 32'd0;
      ip_dst_q  <= 32'd0;
      seq_q     <= 32'd0;
      ack_q     <= 32'd0;
      sport_q   <= 16'd0;
      dport_q   <= 16'd0;
      flags_q   <= 8'd0;
      address_q <= 9'd0;
      ram_out_q <= 32'd0;
      wren_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      dcnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      widx_q    <= widx_d;
      base_q    <= base_d;
      mac_dst_q <= mac_dst_d;
      mac_src_q <= mac_src_d;
      ip_src_q  <= ip_src_d;
      ip_dst_q  <= ip_dst_d;
      seq_q     <= seq_d;
      ack_q     <= ack_d;
      sport_q   <= sport_d;
      dport_q   <= dport_d;
      flags_q   <= flags_d;
      address_q <= address_d;
      ram_out_q <= ram_out_d;
      wren_q    <= wren_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
      dcnt_q    <= dcnt_d;
    end
  end

  assign address    = address_q;
  assign ram_out    = ram_out_q;
  assign wren       = wren_q;
  assign pkt_done   = done_q;
  assign pkt_drop   = drop_q;
  assign drop_count = dcnt_q;

endmodule

// File: tb/tb_tcp_rx_record_writer.sv
// Bench for tcp_rx_record_writer: frames are built byte-wise from header fields and the
// expected record / drop outcome is derived from those fields.
module tb_tcp_rx_record_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] in_data;
  logic        in_valid, in_sop, in_eop, in_ready;
  logic [8:0]  slot_base, address;
  logic [31:0] ram_out;
  logic        wren, pkt_done, pkt_drop;
  logic [15:0] drop_count;

  tcp_rx_record_writer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_ready(in_ready), .slot_base(slot_base), .address(address),
    .ram_out(ram_out), .wren(wren), .pkt_done(pkt_done), .pkt_drop(pkt_drop),
    .drop_count(drop_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed RAM writes and pulses
  int          cyc = 0;
  logic [8:0]  wa[$];
  logic [31:0] wd[$];
  int          wcyc[$];
  int          done_cnt = 0, drop_seen = 0, rdy_low = 0;
  logic        done_wren = 1'b0;
  logic [8:0]  done_addr = 9'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wren === 1'b1) begin
      wa.push_back(address);
      wd.push_back(ram_out);
      wcyc.push_back(cyc);
    end
    if (pkt_done === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      done_wren <= wren;
      done_addr <= address;
    end
    if (pkt_drop === 1'b1) drop_seen <= drop_seen + 1;
    if (in_ready === 1'b0) rdy_low <= rdy_low + 1;
  end

  // Reference frame fields
  logic [47:0] f_mac_dst, f_mac_src;
  logic [15:0] f_etype, f_sport, f_dport;
  logic [3:0]  f_ver, f_ihl;
  logic [7:0]  f_proto, f_flags;
  logic [31:0] f_ipsrc, f_ipdst, f_seq, f_ack;
  logic [31:0] fw[0:31];
  bit          gaps = 1'b0;
  int          exp_done = 0, exp_drops = 0, exp_dc = 0;

  task automatic rand_fields();
    f_mac_dst = {16'($urandom), 32'($urandom)};
    f_mac_src = {16'($urandom), 32'($urandom)};
    f_ipsrc = $urandom; f_ipdst = $urandom; f_seq = $urandom; f_ack = $urandom;
    f_sport = 16'($urandom); f_dport = 16'($urandom); f_flags = 8'($urandom);
    f_etype = 16'h0800; f_ver = 4'd4; f_ihl = 4'd5; f_proto = 8'h06;
  endtask

  task automatic build(input int n_pay);
    logic [7:0] b[0:47];
    for (int i = 0; i < 48; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      b[i]     = f_mac_dst[8*(5-i) +: 8];
      b[6 + i] = f_mac_src[8*(5-i) +: 8];
    end
    b[12] = f_etype[15:8]; b[13] = f_etype[7:0]; b[14] = {f_ver, f_ihl}; b[23] = f_proto;
    for (int i = 0; i < 4; i++) begin
      b[26 + i] = f_ipsrc[8*(3-i) +: 8];
      b[30 + i] = f_ipdst[8*(3-i) +: 8];
      b[38 + i] = f_seq[8*(3-i) +: 8];
      b[42 + i] = f_ack[8*(3-i) +: 8];
    end
    b[34] = f_sport[15:8]; b[35] = f_sport[7:0];
    b[36] = f_dport[15:8]; b[37] = f_dport[7:0];
    b[46] = 8'h50; b[47] = f_flags;
    for (int w = 0; w < 12; w++) fw[w] = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
    for (int i = 0; i < n_pay; i++) fw[12 + i] = $urandom;
  endtask

  // Record word expected at slot offset k
  function automatic logic [31:0] exp_word(input int k);
    case (k)
      1: return f_seq;
      2: return f_ack;
      3: return f_ipsrc;
      4: return f_ipdst;
      5: return f_mac_src[31:0];
      6: return {f_mac_dst[15:0], f_mac_src[47:32]};
      7: return f_mac_dst[47:16];
      8: return {f_dport, f_sport};
      default: return {f_flags, 23'd0, 1'b1};
    endcase
  endfunction

  task automatic send(input int n, input bit with_eop, input logic [8:0] base,
                      output int eop_cyc);
    int i = 0;
    int guard = 0;
    eop_cyc = -1;
    while (i < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_data = $urandom; in_sop = 1'($urandom); in_eop = 1'($urandom);
        slot_base = 9'($urandom);
      end else begin
        in_valid = 1'b1; in_data = fw[i]; in_sop = (i == 0);
        in_eop = with_eop && (i == n - 1);
        slot_base = (i == 0) ? base : 9'($urandom);
        if (in_ready) begin
          if (in_eop) eop_cyc = cyc;
          i++;
        end
      end
    end
    if (guard >= 1000) check("send_timeout", 64'(guard), 64'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int n, input logic [8:0] base,
                           input bit ok, output int wr0);
    int rdy0, ec;
    rdy0 = rdy_low;
    wr0  = wa.size();
    send(n, 1'b1, base, ec);
    if (ok) begin
      exp_done++;
      for (int t = 0; t < 60 && done_cnt != exp_done; t++) @(negedge clk);
      #1;
      check({tag, "_done"}, 64'(done_cnt), 64'(exp_done));
      check({tag, "_nwr"}, 64'(wa.size() - wr0), 64'(9));
      if (wa.size() - wr0 == 9) begin
        for (int j = 0; j < 9; j++) begin
          check({tag, "_addr"}, 64'(wa[wr0 + j]), 64'(9'(base + 9'((j + 1) % 9))));
          check({tag, "_data"}, 64'(wd[wr0 + j]), 64'(exp_word((j + 1) % 9)));
        end
        check({tag, "_latency"}, 64'(wcyc[wr0]), 64'(ec + 1));
      end
      check({tag, "_done_wren"}, 64'(done_wren), 64'(1));
      check({tag, "_done_addr"}, 64'(done_addr), 64'(base));
      check({tag, "_rdy_low"}, 64'(rdy_low - rdy0), 64'(9));
    end else begin
      exp_drops++;
      if (exp_dc < 65535) exp_dc++;
      repeat (4) @(negedge clk);
      #1;
      check({tag, "_drops"}, 64'(drop_seen), 64'(exp_drops));
      check({tag, "_nwr"}, 64'(wa.size() - wr0), 64'(0));
      check({tag, "_rdy_low"}, 64'(rdy_low - rdy0), 64'(0));
    end
    check({tag, "_dcnt"}, 64'(drop_count), 64'(exp_dc));
  endtask

  initial begin
    int w0, ec, n, nw, corrupt, wra, rdya;
    bit ok;
    reset = 1'b0; in_data = 32'd0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    slot_base = 9'd0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_wren", 64'(wren), 64'(0));
    check("rst_address", 64'(address), 64'(0));
    check("rst_ram_out", 64'(ram_out), 64'(0));
    check("rst_done", 64'(pkt_done), 64'(0));
    check("rst_drop", 64'(pkt_drop), 64'(0));
    check("rst_dcnt", 64'(drop_count), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Words without sop while idle must be ignored
    rand_fields(); build(0);
    for (int i = 3; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = fw[i]; in_sop = 1'b0; in_eop = (i == 5);
    end
    @(negedge clk); in_valid = 1'b0; in_eop = 1'b0;

    // SYN frame, eop on w11
    rand_fields();
    f_ipsrc = 32'hC0A80001; f_ipdst = 32'hC0A80002; f_sport = 16'h1234; f_dport = 16'h0050;
    f_seq = 32'h11223344; f_ack = 32'd0; f_flags = 8'h02;
    build(0);
    run_frame("syn", 12, 9'h020, 1'b1, w0);
    if (wd.size() >= w0 + 9) begin
      check("syn_w28", 64'(wd[w0 + 7]), 64'(32'h00501234));
      check("syn_w20", 64'(wd[w0 + 8]), 64'(32'h02000001));
      check("syn_a20", 64'(wa[w0 + 8]), 64'(9'h020));
    end
    check("syn_once", 64'(done_cnt), 64'(1));

    build(4);
    run_frame("syn_pay", 16, 9'h020, 1'b1, w0);

    f_etype = 16'h86DD; build(0);
    run_frame("etype", 12, 9'h040, 1'b0, w0);
    check("etype_dc1", 64'(drop_count), 64'(16'd1));
    f_etype = 16'h0800; f_proto = 8'h11; build(0);
    run_frame("udp", 12, 9'h040, 1'b0, w0);
    check("udp_dc2", 64'(drop_count), 64'(16'd2));

    f_proto = 8'h06; build(0);
    run_frame("runt", 7, 9'h060, 1'b0, w0);

    // A frame interrupted by sop at w7, then a complete one
    rand_fields(); build(0);
    wra = wa.size(); rdya = rdy_low;
    send(7, 1'b0, 9'h080, ec);
    exp_drops++; exp_dc++;
    rand_fields(); build(0);
    run_frame("abort", 12, 9'h0A0, 1'b1, w0);
    check("abort_drops", 64'(drop_seen), 64'(exp_drops));
    check("abort_nwr", 64'(wa.size() - wra), 64'(9));

    rand_fields(); build(2);
    run_frame("wrap", 14, 9'h1FC, 1'b1, w0);

    // Randomized frames with gaps, corruptions and truncations
    gaps = 1'b1;
    for (int f = 0; f < 30; f++) begin
      rand_fields();
      corrupt = $urandom_range(0, 7);
      case (corrupt)
        0: f_etype = 16'h86DD;
        1: f_ver = 4'd6;
        2: f_ihl = 4'(6 + $urandom_range(0, 9));
        3: f_proto = 8'h11;
        default: f_proto = 8'h06;
      endcase
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 11) : 12 + $urandom_range(0, 4);
      build(n > 12 ? n - 12 : 0);
      ok = (corrupt > 3) && (n >= 12);
      run_frame("rand", n, 9'($urandom), ok, w0);
    end
    gaps = 1'b0;

    // Reset during the 4th write cycle
    rand_fields(); build(0);
    wra = wa.size();
    send(12, 1'b1, 9'h100, ec);
    nw = 0;
    for (int t = 0; t < 40; t++) begin
      if (wren) nw++;
      if (nw == 4) break;
      @(posedge clk); #1;
    end
    check("rw_reached4", 64'(nw), 64'(4));
    reset = 1'b0;
    #1;
    exp_dc = 0;
    check("rw_wren", 64'(wren), 64'(0));
    check("rw_address", 64'(address), 64'(0));
    check("rw_ram_out", 64'(ram_out), 64'(0));
    check("rw_done", 64'(pkt_done), 64'(0));
    check("rw_in_ready", 64'(in_ready), 64'(1));
    check("rw_dcnt", 64'(drop_count), 64'(exp_dc));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    check("rw_nwr", 64'(wa.size() - wra), 64'(3));
    for (int j = wra; j < wa.size(); j++) check("rw_no_valid", 64'(wa[j] == 9'h100), 64'(0));
    check("rw_no_done", 64'(done_cnt), 64'(exp_done));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
